// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: feeds one nibble per cycle to an external 4-bit CLA slice
// and chains the slice carry through a register.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_carry
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             carry_q, carry_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             accept;
  logic             last;
  logic [3:0]       nib_a, nib_b;

  assign accept = start && (state_q == StIdle || state_q == StDone);
  assign last   = (state_q == StRun) && (idx_q == LastIdx);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Nibble select as an explicit mux so the index never needs arithmetic widening
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IdxW'(i)) begin
        nib_a = opa_q[4*i +: 4];
        nib_b = opb_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    if (accept) begin
      opa_d    = a;
      opb_d    = b;
      carry_d  = cin;
      idx_d    = '0;
      shadow_d = '0;
    end else if (state_q == StRun) begin
      for (int i = 0; i < NIB; i++) begin
        if (idx_q == IdxW'(i)) shadow_d[4*i +: 4] = add_sum;
      end
      carry_d = add_carry;
      if (last) begin
        sum_d  = shadow_d;
        cout_d = add_carry;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q    <= '0;
      opb_q    <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
    end
  end

  // Outputs
  always_comb begin
    busy    = (state_q == StRun);
    done    = (state_q == StDone);
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state_q == StRun) begin
      add_a   = nib_a;
      add_b   = nib_b;
      add_cin = carry_q;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
